// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU instruction sequencer: FSM states, ALU op codes
// and the op legality check applied when an instruction is accepted.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: op_legal = 1'b1;
            default:                                    op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq.sv
// Sequences one instruction through regfile read, ALU execute and write-back.
// Latency 4 cycles accept-to-ready (2 for illegal ops); in_ready only in IDLE.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [4:0]       in_rd,
    input  logic             in_imm_en,
    input  logic [31:0]      in_imm,
    output logic [4:0]       A1,
    output logic [4:0]       A2,
    output logic [4:0]       A3,
    output logic [31:0]      WD3,
    output logic             WE3,
    input  logic [31:0]      RD1,
    input  logic [31:0]      RD2,
    output logic [31:0]      SrcA,
    output logic [31:0]      SrcB,
    output logic [2:0]       ALUControl,
    input  logic [31:0]      ALUResult,
    output logic             done,
    output logic             err,
    output logic [31:0]      result,
    output logic             zero,
    output logic [CNT_W-1:0] instr_count
);

    state_t             r_state;
    logic [2:0]         r_op;
    logic [4:0]         r_rs1;
    logic [4:0]         r_rs2;
    logic [4:0]         r_rd;
    logic               r_imm_en;
    logic [31:0]        r_imm;
    logic               r_in_ready;
    logic [4:0]         r_a1;
    logic [4:0]         r_a2;
    logic [4:0]         r_a3;
    logic [31:0]        r_res;
    logic               r_we3;
    logic [31:0]        r_opa;
    logic [31:0]        r_opb;
    logic [2:0]         r_alu_ctl;
    logic               r_done;
    logic               r_err;
    logic [31:0]        r_result;
    logic               r_zero;
    logic [CNT_W-1:0]   r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_op       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_imm_en   <= 1'b0;
            r_imm      <= '0;
            r_in_ready <= 1'b1;
            r_a1       <= '0;
            r_a2       <= '0;
            r_a3       <= '0;
            r_res      <= '0;
            r_we3      <= 1'b0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_alu_ctl  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_result   <= '0;
            r_zero     <= 1'b1;
            r_cnt      <= '0;
        end else begin
            // Per-state outputs are pulsed: cleared each edge, set only for the next state.
            r_a1      <= '0;
            r_a2      <= '0;
            r_a3      <= '0;
            r_res     <= '0;
            r_we3     <= 1'b0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_alu_ctl <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op       <= in_op;
                        r_rs1      <= in_rs1;
                        r_rs2      <= in_rs2;
                        r_rd       <= in_rd;
                        r_imm_en   <= in_imm_en;
                        r_imm      <= in_imm;
                        r_in_ready <= 1'b0;
                        if (op_legal(in_op)) begin
                            r_a1    <= in_rs1;
                            r_a2    <= in_rs2;
                            r_state <= ST_READ;
                        end else begin
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                            r_state <= ST_WB;
                        end
                    end
                end
                ST_READ: begin
                    r_opa     <= RD1;
                    r_opb     <= r_imm_en ? r_imm : RD2;
                    r_alu_ctl <= r_op;
                    r_state   <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_a3     <= r_rd;
                    r_res    <= ALUResult;
                    r_we3    <= (r_rd != 5'd0);
                    r_done   <= 1'b1;
                    r_result <= ALUResult;
                    r_zero   <= (ALUResult == 32'd0);
                    r_cnt    <= r_cnt + CNT_W'(1);
                    r_state  <= ST_WB;
                end
                ST_WB: begin
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign A1          = r_a1;
    assign A2          = r_a2;
    assign A3          = r_a3;
    assign WD3         = r_res;
    assign WE3         = r_we3;
    assign SrcA        = r_opa;
    assign SrcB        = r_opb;
    assign ALUControl  = r_alu_ctl;
    assign done        = r_done;
    assign err         = r_err;
    assign result      = r_result;
    assign zero        = r_zero;
    assign instr_count = r_cnt;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq driving a behavioural 32x32 register file and ALU.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_imm_en;
    logic [31:0] in_imm;
    logic [4:0]  A1, A2, A3;
    logic [31:0] WD3;
    logic        WE3;
    logic [31:0] RD1, RD2;
    logic [31:0] SrcA, SrcB;
    logic [2:0]  ALUControl;
    logic [31:0] ALUResult;
    logic        done, err;
    logic [31:0] result;
    logic        zero;
    logic [15:0] instr_count;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] rf [32] = '{default: 32'd0};

    always #5 clk = ~clk;

    alu_seq #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_imm_en(in_imm_en), .in_imm(in_imm),
        .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .WE3(WE3),
        .RD1(RD1), .RD2(RD2),
        .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl), .ALUResult(ALUResult),
        .done(done), .err(err), .result(result), .zero(zero),
        .instr_count(instr_count)
    );

    // Register file: x0 hardwired to zero, combinational read, write on clock edge.
    assign RD1 = (A1 == 5'd0) ? 32'd0 : rf[A1];
    assign RD2 = (A2 == 5'd0) ? 32'd0 : rf[A2];
    always @(posedge clk) if (WE3 && A3 != 5'd0) rf[A3] <= WD3;

    always_comb begin
        ALUResult = 32'd0;
        case (ALUControl)
            3'b000:  ALUResult = SrcA & SrcB;
            3'b001:  ALUResult = SrcA | SrcB;
            3'b010:  ALUResult = SrcA + SrcB;
            3'b110:  ALUResult = SrcA - SrcB;
            3'b111:  ALUResult = ($signed(SrcA) < $signed(SrcB)) ? 32'd1 : 32'd0;
            default: ALUResult = 32'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic imm_en, input logic [31:0] imm);
        in_valid  = 1'b1;
        in_op     = op;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_rd     = rd;
        in_imm_en = imm_en;
        in_imm    = imm;
    endtask

    // Full legal instruction with per-cycle checks; exp_res is hand-computed by the caller.
    task automatic run_legal(input string tag, input logic [2:0] op, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd, input logic imm_en,
                             input logic [31:0] imm, input logic [31:0] exp_res);
        @(negedge clk);
        drive(op, rs1, rs2, rd, imm_en, imm);
        chk({tag, ".ready_c0"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".A1_c1"}, 32'(A1), 32'(rs1));
        chk({tag, ".done_c1"}, 32'(done), 32'd0);
        @(negedge clk);
        chk({tag, ".aluctl_c2"}, 32'(ALUControl), 32'(op));
        chk({tag, ".we_c2"}, 32'(WE3), 32'd0);
        @(negedge clk);
        chk({tag, ".done_c3"}, 32'(done), 32'd1);
        chk({tag, ".err_c3"}, 32'(err), 32'd0);
        chk({tag, ".we_c3"}, 32'(WE3), (rd != 5'd0) ? 32'd1 : 32'd0);
        if (rd != 5'd0) begin
            chk({tag, ".A3_c3"}, 32'(A3), 32'(rd));
            chk({tag, ".WD3_c3"}, WD3, exp_res);
        end
        chk({tag, ".result"}, result, exp_res);
        chk({tag, ".zero"}, 32'(zero), (exp_res == 32'd0) ? 32'd1 : 32'd0);
        @(negedge clk);
        chk({tag, ".ready_c4"}, 32'(in_ready), 32'd1);
        chk({tag, ".done_c4"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive(3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
        in_valid = 1'b0;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst.ready", 32'(in_ready), 32'd1);
        chk("rst.we", 32'(WE3), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.result", result, 32'd0);
        chk("rst.zero", 32'(zero), 32'd1);
        chk("rst.count", 32'(instr_count), 32'd0);
        chk("rst.A1", 32'(A1), 32'd0);

        // Immediate loads: r1=5, r2=3
        run_legal("addi1", ALU_ADD, 5'd0, 5'd0, 5'd1, 1'b1, 32'd5, 32'd5);
        run_legal("addi2", ALU_ADD, 5'd0, 5'd0, 5'd2, 1'b1, 32'd3, 32'd3);
        chk("imm.count", 32'(instr_count), 32'd2);
        chk("imm.rf1", rf[1], 32'd5);

        // Register ops
        run_legal("sub", ALU_SUB, 5'd1, 5'd2, 5'd3, 1'b0, 32'd0, 32'd2);
        run_legal("slt", ALU_SLT, 5'd2, 5'd1, 5'd4, 1'b0, 32'd0, 32'd1);
        run_legal("subz", ALU_SUB, 5'd1, 5'd1, 5'd5, 1'b0, 32'd0, 32'd0);
        chk("reg.rf3", rf[3], 32'd2);
        chk("reg.rf4", rf[4], 32'd1);
        chk("reg.count", 32'(instr_count), 32'd5);

        // Illegal op 100: done+err one cycle after accept, no write, counter held
        @(negedge clk);
        drive(3'b100, 5'd1, 5'd2, 5'd6, 1'b0, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ill.done_c1", 32'(done), 32'd1);
        chk("ill.err_c1", 32'(err), 32'd1);
        chk("ill.we_c1", 32'(WE3), 32'd0);
        chk("ill.count", 32'(instr_count), 32'd5);
        chk("ill.result", result, 32'd0);
        @(negedge clk);
        chk("ill.ready_c2", 32'(in_ready), 32'd1);
        chk("ill.done_c2", 32'(done), 32'd0);
        chk("ill.rf6", rf[6], 32'd0);

        // Write to x0 is suppressed but result still reported
        run_legal("rd0", ALU_ADD, 5'd0, 5'd0, 5'd0, 1'b1, 32'd7, 32'd7);
        chk("rd0.count", 32'(instr_count), 32'd6);
        chk("rd0.rf0", rf[0], 32'd0);

        // Reset during EXEC: no write-back, no done, back to IDLE
        @(negedge clk);
        drive(ALU_ADD, 5'd0, 5'd0, 5'd6, 1'b1, 32'd9);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid.in_exec", 32'(ALUControl), 32'(ALU_ADD));
        rst = 1'b1;
        @(negedge clk);
        chk("mid.done", 32'(done), 32'd0);
        chk("mid.we", 32'(WE3), 32'd0);
        chk("mid.ready", 32'(in_ready), 32'd1);
        chk("mid.count", 32'(instr_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid.done_after", 32'(done), 32'd0);
        chk("mid.rf6", rf[6], 32'd0);

        // in_valid held through READ/EXEC/WB is accepted only once: r7 = r1 + 4 = 9
        @(negedge clk);
        drive(ALU_ADD, 5'd1, 5'd0, 5'd7, 1'b1, 32'd4);
        @(negedge clk);
        chk("hold.A1_c1", 32'(A1), 32'd1);
        chk("hold.ready_c1", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("hold.srca_c2", SrcA, 32'd5);
        chk("hold.srcb_c2", SrcB, 32'd4);
        @(negedge clk);
        in_valid = 1'b0;
        chk("hold.done_c3", 32'(done), 32'd1);
        chk("hold.wd3_c3", WD3, 32'd9);
        @(negedge clk);
        chk("hold.ready_c4", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("hold.ready_c5", 32'(in_ready), 32'd1);
        chk("hold.count", 32'(instr_count), 32'd1);
        chk("hold.rf7", rf[7], 32'd9);
        chk("hold.result", result, 32'd9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
